// File: rtl/pulse_width_decoder.sv
// Measures the high time of a stretched pulse on din and collapses a legal-width pulse to a one-cycle strobe.
// Latency: strobes 3 cycles after din is first sampled low (SYNC_EN=1), 1 cycle (SYNC_EN=0); no backpressure.
module pulse_width_decoder #(
    parameter int EXP_LEN = 10,
    parameter int TOL     = 1,
    parameter int CNT_W   = 8,
    parameter int SYNC_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr,
    output logic             pulse_out,
    output logic [CNT_W-1:0] width,
    output logic             width_vld,
    output logic             err_short,
    output logic             err_long,
    output logic             err_sticky,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MEAS, OVR} state_t;

    localparam logic [CNT_W-1:0] LO_LIM   = CNT_W'(EXP_LEN - TOL);
    localparam logic [CNT_W-1:0] HI_LIM   = CNT_W'(EXP_LEN + TOL);
    localparam logic [CNT_W:0]   LONG_CNT = (CNT_W+1)'(EXP_LEN + TOL + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             din_s;
    logic             prev;
    logic             rise;
    logic             fall;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;

    // Flops reset high so a din already asserted at reset release is not seen as a pulse.
    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sync_q <= 2'b11;
                else        sync_q <= {sync_q[0], din};
            end
            assign din_s = sync_q[1];
        end else begin : g_nosync
            assign din_s = din;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= din_s;
    end

    assign rise    = din_s & ~prev;
    assign fall    = ~din_s & prev;
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign cnt_sat = (&cnt) ? cnt : cnt_inc[CNT_W-1:0];
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            width      <= '0;
            pulse_out  <= 1'b0;
            width_vld  <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            pulse_out  <= 1'b0;
            width_vld  <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            // A strobe coinciding with clr keeps the flag set.
            err_sticky <= err_short | err_long | (err_sticky & ~clr);
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt   <= CNT_W'(1);
                        state <= MEAS;
                    end
                end
                MEAS: begin
                    if (din_s) begin
                        cnt <= cnt_sat;
                        if (cnt_inc == LONG_CNT) begin
                            err_long <= 1'b1;
                            state    <= OVR;
                        end
                    end else if (fall) begin
                        width     <= cnt;
                        width_vld <= 1'b1;
                        if (cnt >= LO_LIM && cnt <= HI_LIM) pulse_out <= 1'b1;
                        else                                err_short <= 1'b1;
                        state <= IDLE;
                    end
                end
                OVR: begin
                    if (din_s) begin
                        cnt <= cnt_sat;
                    end else if (fall) begin
                        width     <= cnt;
                        width_vld <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pulse_width_decoder.md
Name: pulse_width_decoder

Overview:
- Receive-side counterpart of the team's fixed-length pulse stretcher: measures the high time of a stretched pulse on `din` and decides whether it is a legal pulse of nominal length EXP_LEN (±TOL clock cycles).
- A legal pulse collapses back to a single-cycle `pulse_out` strobe. An illegal pulse raises an error flag.
- Sits at the far end of a pulse link, e.g. on a slower or different-domain board signal, so an optional two-flop input synchronizer is included.

Parameters:
- EXP_LEN, 10, nominal pulse width in clk cycles.
- TOL, 1, allowed deviation in cycles. Legal window is [EXP_LEN-TOL, EXP_LEN+TOL]. Requires TOL < EXP_LEN.
- CNT_W, 8, width of the measurement counter and of `width`. Requires EXP_LEN+TOL+1 < 2^CNT_W-1.
- SYNC_EN, 1, 1 = two-flop synchronizer on `din`; 0 = `din` used directly.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, 1, stretched pulse input, active high.
- clr, input, 1, synchronous clear of `err_sticky`.
- pulse_out, output, 1, one-cycle strobe when a legal pulse ends.
- width, output, CNT_W, measured width of the last completed pulse; held until the next pulse ends.
- width_vld, output, 1, one-cycle strobe when `width` updates (every completed pulse).
- err_short, output, 1, one-cycle strobe: the pulse ended below EXP_LEN-TOL.
- err_long, output, 1, one-cycle strobe: the pulse exceeded EXP_LEN+TOL.
- err_sticky, output, 1, set by either error strobe; cleared by `clr` or reset.
- busy, output, 1, high while a pulse is being measured (state MEAS or OVR).

Behaviour:
- **Reset and clock.** Reset is rst_n, asynchronous, active-low; clock is clk. All flops reset asynchronously.
- **Output reset values.** pulse_out, width_vld, err_short, err_long and err_sticky = 0; width = 0; busy = 0; state = IDLE.
- **Input conditioning.**
  - Synchronizer flops and the edge-detect "previous" flop reset to 1. A `din` already high at reset release is therefore not a pulse; it is ignored until it goes low.
  - `din_s` = synchronized `din`.
  - Rising edge = `din_s` & !prev. Falling edge = !`din_s` & prev.
- **Counting.** If `din` is high for N consecutive clk samples, the measured count is exactly N. The count saturates at 2^CNT_W-1 and never wraps.
- **State machine IDLE.** On a rising edge: cnt <= 1, go to MEAS. Otherwise stay.
- **State machine MEAS.**
  - `din_s`=1: cnt <= cnt+1.
  - If cnt+1 == EXP_LEN+TOL+1: assert `err_long` for one cycle and go to OVR.
  - Falling edge: width <= cnt and width_vld=1. Then assert pulse_out if cnt is in the legal window, else err_short. Go to IDLE.
- **State machine OVR.** Keep counting (saturating). On a falling edge: width <= cnt and width_vld=1, with no pulse_out and no second error; go to IDLE.
- **Strobe timing.** All strobes are registered and last exactly one cycle.
- **Latency.**
  - SYNC_EN=1: pulse_out, width_vld and err_short are high in the 3rd cycle after the first clk edge that samples `din` low.
  - SYNC_EN=0: the same strobes are high in the 1st cycle after that edge.
  - err_long fires during the pulse, when the count reaches EXP_LEN+TOL+1.
- **Back-to-back pulses.** A single low sample between pulses is sufficient. The falling-edge cycle returns the FSM to IDLE and the next rising edge is detected normally.
- **err_sticky.** Set/clear priority: an error strobe in the same cycle as `clr` wins (sticky = 1).
- **Reset mid-pulse.** The FSM returns to IDLE; no strobe is emitted for the aborted pulse. If `din` is still high, the remainder is ignored until `din` goes low.

Test Plan:
- EXP_LEN=10, TOL=1, SYNC_EN=1. `din` high 10 cycles → one pulse_out, width=10, width_vld once, no errors, pulse_out 3 cycles after `din` falls.
- Pulses of 9 and 11 → pulse_out each, width=9 then width=11. Pulse of 8 → err_short, width=8, err_sticky=1, no pulse_out. `clr` → err_sticky=0.
- `din` high 20 cycles → err_long while the count reaches 12 (`din` still high); at the fall, width_vld with width=20; no pulse_out; exactly one error strobe.
- 10 high, 1 low, 10 high → two pulse_out strobes 11 cycles apart, width=10 both times. `din` high 300 cycles with CNT_W=8 → width=255, no wrap.
- `din` high through reset release, then low, then a 10-cycle pulse → only the second pulse produces pulse_out.
- Reset asserted at count 5 → all outputs 0 immediately; no strobe for that pulse. The same check with SYNC_EN=0 confirms the 1-cycle latency.
